// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types, default parameters and the round-robin pick
// function for reg_bank_arbiter.
//   state_e    : arbiter FSM states (IDLE, WRITE, ACK)
//   rr_pick_t  : result of a round-robin pick (valid + winner index)
//   rr_next()  : first requester at or after (last+1) mod n
package reg_arb_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int DEPTH_DEF = 4;
    localparam int W_DEF     = 4;

    // Requester indices are carried at the width needed for the largest
    // supported NREQ (8), so one function serves every configuration.
    localparam int RR_MAX = 8;
    localparam int RR_IW  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [RR_IW-1:0] idx;
    } rr_pick_t;

    // Scan n candidates starting just after 'last', wrapping at n. Bits of
    // req at or above n are ignored.
    function automatic rr_pick_t rr_next(input logic [RR_MAX-1:0] req,
                                         input int unsigned        n,
                                         input logic [RR_IW-1:0]   last);
        rr_pick_t    r;
        int unsigned cand;
        r    = '0;
        cand = 0;
        for (int unsigned k = 1; k <= RR_MAX; k++) begin
            if (k <= n && !r.valid) begin
                cand = (32'(last) + k) % n;
                if (req[cand[RR_IW-1:0]]) begin
                    r.valid = 1'b1;
                    r.idx   = cand[RR_IW-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bank_reg.sv
// bank_reg: one W-bit parallel-load register of the shared bank.
//   clk, reset_n : clock, async active-low reset (clears to 0)
//   load         : capture d at the next rising edge
//   d, q         : parallel data in / registered data out
module bank_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (load) val_d = d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) val_q <= '0;
        else          val_q <= val_d;
    end

    assign q = val_q;

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin write arbiter in front of a DEPTH-entry bank
// of W-bit registers shared by NREQ requesters.
//   clk, reset_n : clock, async active-low reset
//   req_i        : per-requester write request (level, held until ack)
//   addr_i       : per-requester target register, requester i in slice i
//   data_i       : per-requester write data, requester i in slice i
//   ack_o        : one-cycle acknowledge to the winner (ACK state)
//   grant_o      : current owner, one-hot during WRITE and ACK
//   busy_o       : high in WRITE and ACK
//   rd_addr_i    : read address
//   rd_data_o    : bank[rd_addr_i], combinational
//   bank_o       : all bank registers, entry i in slice i
// A transaction takes three cycles: IDLE (arbitrate and latch), WRITE
// (load pulse), ACK (acknowledge, advance round-robin pointer).
module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = W_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*W-1:0]  data_i,
    output logic [NREQ-1:0]    ack_o,
    output logic [NREQ-1:0]    grant_o,
    output logic               busy_o,
    input  logic [AW-1:0]      rd_addr_i,
    output logic [W-1:0]       rd_data_o,
    output logic [DEPTH*W-1:0] bank_o
);

    state_e           state_q,  state_d;
    logic [RR_IW-1:0] winner_q, winner_d;
    logic [RR_IW-1:0] last_q,   last_d;
    logic [AW-1:0]    addr_q,   addr_d;
    logic [W-1:0]     data_q,   data_d;

    logic [RR_MAX-1:0]          req_ext;
    rr_pick_t                   pick;
    int unsigned                sel;
    logic [NREQ-1:0]            winner_oh;
    logic [DEPTH-1:0]           load;
    logic [DEPTH-1:0][W-1:0]    bank_q;

    // Next-state, arbitration and capture. addr/data are only sampled in
    // IDLE, so later changes on the requester buses cannot affect the write.
    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req_i;
        pick                = rr_next(req_ext, NREQ, last_q);
        sel                 = 32'(pick.idx);

        state_d  = state_q;
        winner_d = winner_q;
        last_d   = last_q;
        addr_d   = addr_q;
        data_d   = data_q;

        case (state_q)
            ST_IDLE: begin
                if (pick.valid) begin
                    winner_d = pick.idx;
                    addr_d   = addr_i[sel*AW +: AW];
                    data_d   = data_i[sel*W +: W];
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Dropping req here does not abort; the ack still follows.
                state_d = ST_ACK;
            end
            ST_ACK: begin
                last_d  = winner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last_q resets to NREQ-1 so requester 0 is first in line after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            winner_q <= '0;
            last_q   <= RR_IW'(NREQ - 1);
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        winner_oh = NREQ'(1) << winner_q;
        busy_o    = (state_q != ST_IDLE);
        grant_o   = busy_o ? winner_oh : '0;
        ack_o     = (state_q == ST_ACK) ? winner_oh : '0;
    end

    // One load pulse per transaction, to the latched address only.
    for (genvar g = 0; g < DEPTH; g++) begin : g_bank
        assign load[g] = (state_q == ST_WRITE) && (addr_q == AW'(g));

        bank_reg #(.W(W)) u_bank (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (load[g]),
            .d       (data_q),
            .q       (bank_q[g])
        );
    end

    assign bank_o    = bank_q;
    assign rd_data_o = bank_q[rd_addr_i];

endmodule

// File: tb/tb_reg_bank_arbiter.sv
module tb_reg_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int DEPTH = 4;
    localparam int W     = 4;
    localparam int AW    = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NREQ-1:0]    req_i;
    logic [NREQ*AW-1:0] addr_i;
    logic [NREQ*W-1:0]  data_i;
    logic [NREQ-1:0]    ack_o;
    logic [NREQ-1:0]    grant_o;
    logic               busy_o;
    logic [AW-1:0]      rd_addr_i;
    logic [W-1:0]       rd_data_o;
    logic [DEPTH*W-1:0] bank_o;

    reg_bank_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     (req_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .ack_o     (ack_o),
        .grant_o   (grant_o),
        .busy_o    (busy_o),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_o),
        .bank_o    (bank_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]    ack;
        logic [DEPTH*W-1:0] bank;
        int                 gap;   // required cycles since previous ack, 0 = any
    } exp_t;

    exp_t            sb[$];
    int              tests = 0;
    int              fails = 0;
    int              cyc = 0;
    int              last_ack_cyc = -1;
    logic [NREQ-1:0] hold;
    logic [W-1:0]    rd_exp [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [NREQ-1:0] a, input logic [DEPTH*W-1:0] b, input int g);
        exp_t e;
        e.ack = a; e.bank = b; e.gap = g;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [W-1:0] d);
        addr_i[i*AW +: AW] = a;
        data_i[i*W +: W]   = d;
    endtask

    // Requesters not in 'hold' drop their request during their ack cycle.
    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            req_i = req_i & ~(ack_o & ~hold);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ack is matched against the next scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (ack_o !== '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(ack_o), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack", 32'(ack_o), 32'(e.ack));
                chk("ack_bank", 32'(bank_o), 32'(e.bank));
                if (e.gap > 0 && last_ack_cyc >= 0)
                    chk("ack_gap", cyc - last_ack_cyc, e.gap);
            end
            last_ack_cyc <= cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; req_i = '0; addr_i = '0; data_i = '0;
        rd_addr_i = '0; hold = '0;
        rd_exp = '{4'h5, 4'h4, 4'h7, 4'h6};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant_o), 0);
        chk("rst_ack",   32'(ack_o), 0);
        chk("rst_busy",  32'(busy_o), 0);
        chk("rst_bank",  32'(bank_o), 0);
        chk("rst_rd",    32'(rd_data_o), 0);
        reset_n = 1'b1;
        cycles(1);

        // Single request: requester 0 writes A to bank[2]
        set_req(0, 2'd2, 4'hA);
        rd_addr_i = 2'd2;
        push(4'b0001, 16'h0A00, 0);
        req_i = 4'b0001;
        cycles(1);
        chk("t1_grant", 32'(grant_o), 32'h1);
        chk("t1_busy",  32'(busy_o), 1);
        chk("t1_bank_before_e1", 32'(bank_o), 0);
        cycles(1);
        chk("t1_rd_after_e1", 32'(rd_data_o), 32'hA);
        cycles(1);
        chk("t1_idle_busy",  32'(busy_o), 0);
        chk("t1_idle_grant", 32'(grant_o), 0);
        chk("t1_ack_one_cycle", 32'(ack_o), 0);
        chk("t1_bank", 32'(bank_o), 32'h0A00);

        // All four request bank[1]; served 0,1,2,3 three cycles apart
        reset_n = 1'b0;
        cycles(1);
        reset_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 2'd1, 4'(i + 1));
        push(4'b0001, 16'h0010, 0);
        push(4'b0010, 16'h0020, 3);
        push(4'b0100, 16'h0030, 3);
        push(4'b1000, 16'h0040, 3);
        req_i = 4'b1111;
        cycles(13);
        chk("t2_bank", 32'(bank_o), 32'h0040);
        chk("t2_busy", 32'(busy_o), 0);

        // Fairness: 0 and 2 keep requesting, grants alternate
        hold = 4'b0101;
        set_req(0, 2'd0, 4'h5);
        set_req(2, 2'd3, 4'h6);
        push(4'b0001, 16'h0045, 0);
        push(4'b0100, 16'h6045, 3);
        push(4'b0001, 16'h6045, 3);
        push(4'b0100, 16'h6045, 3);
        req_i = 4'b0101;
        cycles(11);
        hold  = '0;
        req_i = '0;
        cycles(2);
        chk("t3_busy",  32'(busy_o), 0);
        chk("t3_grant", 32'(grant_o), 0);

        // Late change of addr/data and req drop during WRITE
        set_req(1, 2'd2, 4'h7);
        push(4'b0010, 16'h6745, 0);
        req_i = 4'b0010;
        cycles(1);
        chk("t4_grant", 32'(grant_o), 32'h2);
        set_req(1, 2'd0, 4'hF);
        req_i = '0;
        cycles(2);
        chk("t4_bank", 32'(bank_o), 32'h6745);
        chk("t4_busy", 32'(busy_o), 0);

        // Read port sweep
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr_i = AW'(a);
            #1;
            chk("rd_sweep", 32'(rd_data_o), 32'(rd_exp[a]));
        end

        // bank[3] = 5, then async reset in the middle of the next WRITE
        set_req(3, 2'd3, 4'h5);
        push(4'b1000, 16'h5745, 0);
        req_i = 4'b1000;
        cycles(4);
        chk("t5_bank_pre", 32'(bank_o), 32'h5745);
        set_req(1, 2'd0, 4'h9);
        req_i = 4'b0010;
        cycles(1);
        chk("t5_grant_mid", 32'(grant_o), 32'h2);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_grant", 32'(grant_o), 0);
        chk("t5_rst_busy",  32'(busy_o), 0);
        chk("t5_rst_ack",   32'(ack_o), 0);
        chk("t5_rst_bank",  32'(bank_o), 0);
        chk("t5_rst_rd",    32'(rd_data_o), 0);
        req_i = '0;
        cycles(2);
        reset_n = 1'b1;
        cycles(1);
        chk("t5_bank_after", 32'(bank_o), 0);

        // After reset priority restarts at requester 0
        set_req(0, 2'd1, 4'h3);
        set_req(1, 2'd1, 4'h8);
        push(4'b0001, 16'h0030, 0);
        push(4'b0010, 16'h0080, 3);
        req_i = 4'b0011;
        cycles(7);
        chk("t5_bank_final", 32'(bank_o), 32'h0080);
        chk("t5_busy_final", 32'(busy_o), 0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Round-robin write arbiter that shares a small bank of 4-bit parallel-load registers between NREQ requesters. Each requester raises a request carrying an address and data. The arbiter grants one winner at a time, pulses that register's load for exactly one cycle, and acknowledges the winner. A combinational read port exposes any bank entry. The block sits between several control agents and the shared configuration/data registers they all update.

## Interface
Parameters:
- NREQ, 4: number of requesters; 2..8.
- DEPTH, 4: number of bank registers; power of two, at least 2.
- W, 4: register width.
- AW, $clog2(DEPTH): address width, derived.

Ports (all requester buses are flattened, requester i in slice i):
- clk  in  1  single clock; rising edge.
- reset_n  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
- req_i  in  NREQ  write request per requester; level; held until ack.
- addr_i  in  NREQ*AW  target register per requester.
- data_i  in  NREQ*W  write data per requester.
- ack_o  out  NREQ  one-cycle acknowledge, one-hot or zero.
- grant_o  out  NREQ  current owner, one-hot or zero.
- busy_o  out  1  high in WRITE and ACK.
- rd_addr_i  in  AW  read address.
- rd_data_o  out  W  bank[rd_addr_i], combinational.
- bank_o  out  DEPTH*W  all registers, flattened.

## Operation
- FSM states: IDLE, WRITE, ACK.
- IDLE: if any req_i bit is set, pick the winner round-robin starting at (last_winner+1) mod NREQ. Latch winner, addr and data. Go to WRITE. Otherwise stay in IDLE.
- WRITE: load asserted for bank[addr_q] only. Register takes data_q at the closing edge. Go to ACK.
- ACK: ack_o[winner] = 1. last_winner <= winner. Go to IDLE. No arbitration in ACK.
- Requesters must drop req during their ack cycle. A req still high in the next IDLE is treated as a new request.
- Changes to addr_i/data_i after grant are ignored, because values are latched.
- Deasserting req_i during WRITE does not abort the write; the ack is still issued.
- Registers hold their value unless loaded. Only one register is loaded per transaction.
- Reset values: state IDLE, last_winner = NREQ-1 (requester 0 has top priority first), grant_o 0, ack_o 0, busy_o 0, all bank registers 0.
- reset_n low mid-transaction: the in-flight write is lost and no ack is issued. Everything returns to reset values immediately.

## Timing
- Request seen high at edge E0 (state IDLE):
  - grant_o and busy_o high after E0.
  - Bank register updated at E1.
  - ack_o high between E1 and E2.
  - State IDLE after E2.
- Latency is request-to-data-visible 2 edges and request-to-ack 2 edges.
- Peak throughput is one write per 3 cycles.
- grant_o is high in WRITE and ACK and zero in IDLE. All outputs except rd_data_o are registered or state-decoded.
- rd_data_o is combinational from the bank and rd_addr_i. A write at E1 is visible on rd_data_o immediately after E1.
- With no requests, the FSM idles and last_winner is unchanged.

## Structure
- Package reg_arb_pkg holds:
  - the state enum (IDLE, WRITE, ACK);
  - default parameter constants;
  - the round-robin next-winner function (request vector plus last index gives index and valid).
- Sub-module bank_reg: one W-bit parallel-load register with clk, reset_n (async, active-low), load, d, q. Instantiated DEPTH times by generate.
- Top holds the FSM, the winner/address/data capture registers, load decode and read mux.

## Test plan
- Reset then single request: req_i=0001, addr=2, data=4'hA. Required: grant 0001 after E0, bank[2]=A at E1, ack_o=0001 for one cycle, bank_o=0x0A00. Other entries stay 0.
- All request, each held until acked: req_i=1111, all addr=1, data=i+1. Required: acks in order 0,1,2,3, 3 cycles apart. Final bank[1]=4.
- Fairness: req0 and req2 continuously re-request. Required: grants alternate 0,2,0,2; neither wins twice in a row.
- Late change: after grant, change addr_i/data_i of the winner. Required: the original latched values are written. Deassert req in WRITE: the write and ack still occur.
- Async reset mid-WRITE: reset_n low between clock edges with bank[3] previously 5. Required: all outputs and bank 0 immediately, no ack. The next request after release is served normally, starting priority at requester 0.
- Read port: sweep rd_addr_i 0..3 after known writes. rd_data_o matches the bank contents in the same cycle.
